// File: rtl/scan_event_counter.sv
// rtl/scan_event_counter.sv - debounced button event counter with multiplexed 7-segment scan
module scan_event_counter #(
    parameter int DIGITS    = 2,
    parameter int BASE      = 10,
    parameter int DB_CYCLES = 1,
    parameter int SCAN_DIV  = 4,
    parameter int LZB       = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BTNC,
    input  logic                  DIR,
    input  logic                  EN,
    input  logic                  CLR,
    output logic [6:0]            SWG,
    output logic [DIGITS-1:0]     AN,
    output logic                  LED0,
    output logic [4*DIGITS-1:0]   VALUE
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int SDW = $clog2(SCAN_DIV + 1);
    localparam int IXW = $clog2(DIGITS + 1);

    localparam logic [DBW-1:0]    DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [SDW-1:0]    SD_LAST  = SDW'(SCAN_DIV - 1);
    localparam logic [IXW-1:0]    IX_LAST  = IXW'(DIGITS - 1);
    localparam logic [3:0]        DIG_MAX  = 4'(BASE - 1);
    localparam logic [DIGITS-1:0] AN_RESET = ~(DIGITS'(1));
    localparam logic [6:0]        SEG_ZERO = 7'b1000000;
    localparam logic [6:0]        SEG_OFF  = 7'h7F;

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic                s1_q, s1_d, s2_q, s2_d;
    logic                vld1_q, vld1_d, vld2_q, vld2_d;
    logic                armed_q, armed_d;
    logic                db_q, db_d;
    logic [DBW-1:0]      db_cnt_q, db_cnt_d;
    logic                strobe_q, strobe_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                led_q, led_d;
    logic [SDW-1:0]      presc_q, presc_d;
    logic [IXW-1:0]      idx_q, idx_d;
    logic [3:0]          shown_q, shown_d;
    logic                blank_q, blank_d;
    logic                load_q, load_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          swg_q, swg_d;
    logic [DIGITS-1:0]   upper_zero;

    // Synchroniser, debounce and press strobe; armed blocks a press held through reset.
    always_comb begin
        s1_d     = BTNC;
        s2_d     = s1_q;
        vld1_d   = 1'b1;
        vld2_d   = vld1_q;
        armed_d  = armed_q | (vld2_q & ~s2_q);
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        strobe_d = 1'b0;
        if (s2_q == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = s2_q;
            db_cnt_d = '0;
            strobe_d = s2_q & armed_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Counter update: clear beats an enabled strobe; ripple carry/borrow across digits.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        value_d = value_q;
        led_d   = led_q;
        carry   = 1'b1;
        dig     = 4'd0;
        if (CLR) begin
            value_d = '0;
            led_d   = 1'b0;
        end else if (strobe_q && EN) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = value_q[4*i +: 4];
                if (carry) begin
                    if (!DIR) begin
                        if (dig == DIG_MAX) begin
                            value_d[4*i +: 4] = 4'd0;
                        end else begin
                            value_d[4*i +: 4] = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            value_d[4*i +: 4] = DIG_MAX;
                        end else begin
                            value_d[4*i +: 4] = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            if (carry) begin
                led_d = 1'b1;
            end
        end
    end

    // upper_zero[i] is set when digit i and every digit above it are zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc           = acc & (value_q[4*i +: 4] == 4'd0);
            upper_zero[i] = acc;
        end
    end

    // Scan prescaler and digit index; the new digit is captured, then shown next cycle.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        shown_d = shown_q;
        blank_d = blank_q;
        load_d  = 1'b0;
        an_d    = an_q;
        swg_d   = swg_q;
        if (presc_q == SD_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IX_LAST) ? '0 : idx_q + 1'b1;
            load_d  = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_d == IXW'(i)) begin
                    shown_d = value_q[4*i +: 4];
                    blank_d = (LZB != 0) && (i != 0) && upper_zero[i];
                end
            end
        end
        if (load_q) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            swg_d = blank_q ? SEG_OFF : seg7(shown_q);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            armed_q  <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            strobe_q <= 1'b0;
            value_q  <= '0;
            led_q    <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            shown_q  <= 4'd0;
            blank_q  <= 1'b0;
            load_q   <= 1'b0;
            an_q     <= AN_RESET;
            swg_q    <= SEG_ZERO;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            vld1_q   <= vld1_d;
            vld2_q   <= vld2_d;
            armed_q  <= armed_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            strobe_q <= strobe_d;
            value_q  <= value_d;
            led_q    <= led_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shown_q  <= shown_d;
            blank_q  <= blank_d;
            load_q   <= load_d;
            an_q     <= an_d;
            swg_q    <= swg_d;
        end
    end

    assign SWG   = swg_q;
    assign AN    = an_q;
    assign LED0  = led_q;
    assign VALUE = value_q;

endmodule

// File: tb/tb_scan_event_counter.sv
// tb/tb_scan_event_counter.sv - checks two scan_event_counter configurations against a reference model
module tb_scan_event_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btnc = 1'b0;
    logic        dir = 1'b0;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic [6:0]  swg_a, swg_b;
    logic [1:0]  an_a;
    logic [2:0]  an_b;
    logic        led_a, led_b;
    logic [7:0]  value_a;
    logic [11:0] value_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_event_counter dut_a (
        .CLK(clk), .RST(rst), .BTNC(btnc), .DIR(dir), .EN(en), .CLR(clr),
        .SWG(swg_a), .AN(an_a), .LED0(led_a), .VALUE(value_a)
    );

    scan_event_counter #(
        .DIGITS(3), .BASE(16), .DB_CYCLES(4), .SCAN_DIV(3), .LZB(1)
    ) dut_b (
        .CLK(clk), .RST(rst), .BTNC(btnc), .DIR(dir), .EN(en), .CLR(clr),
        .SWG(swg_b), .AN(an_b), .LED0(led_b), .VALUE(value_b)
    );

    int p_d[2];
    int p_base[2];
    int p_db[2];
    int p_sd[2];
    int p_lzb[2];
    logic [6:0] seg_tab[16];

    int         k;
    bit         h1, h2;
    int         mv[2];
    bit         ml[2];
    bit         mdb[2];
    int         run[2];
    bit         armed[2];
    bit         pend[2];
    bit         cap_flag[2];
    logic [6:0] cap_swg[2];
    logic [6:0] swg_exp[2];

    function automatic int ipow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic logic [31:0] exp_value(input int inst);
        logic [31:0] r = '0;
        for (int d = 0; d < p_d[inst]; d++)
            r = r | (32'((mv[inst] / ipow(p_base[inst], d)) % p_base[inst]) << (4 * d));
        return r;
    endfunction

    function automatic logic [31:0] exp_an(input int inst);
        int idx;
        idx = (k == 0) ? 0 : ((k - 1) / p_sd[inst]) % p_d[inst];
        return 32'(~(1 << idx) & ((1 << p_d[inst]) - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        h1 = 1'b0;
        h2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; ml[i] = 1'b0; mdb[i] = 1'b0; run[i] = 0;
            armed[i] = 1'b0; pend[i] = 1'b0; cap_flag[i] = 1'b0;
            cap_swg[i] = 7'b1000000; swg_exp[i] = 7'b1000000;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " A.value"}, 32'(value_a), exp_value(0));
        chk({tag, " A.led0"},  32'(led_a),   32'(ml[0]));
        chk({tag, " A.an"},    32'(an_a),    exp_an(0));
        chk({tag, " A.swg"},   32'(swg_a),   32'(swg_exp[0]));
        chk({tag, " B.value"}, 32'(value_b), exp_value(1));
        chk({tag, " B.led0"},  32'(led_b),   32'(ml[1]));
        chk({tag, " B.an"},    32'(an_b),    exp_an(1));
        chk({tag, " B.swg"},   32'(swg_b),   32'(swg_exp[1]));
    endtask

    // One clock: model advances on the edge using the inputs presented before it.
    task automatic step();
        bit s2;
        int idx, modv, hi;
        @(posedge clk);
        k++;
        s2 = (k >= 3) ? h2 : 1'b0;
        for (int i = 0; i < 2; i++) begin
            modv = ipow(p_base[i], p_d[i]);
            if (cap_flag[i]) swg_exp[i] = cap_swg[i];
            cap_flag[i] = 1'b0;
            if (k % p_sd[i] == 0) begin
                idx = (k / p_sd[i]) % p_d[i];
                hi  = mv[i] / ipow(p_base[i], idx);
                if (p_lzb[i] != 0 && idx != 0 && hi == 0) cap_swg[i] = 7'h7F;
                else cap_swg[i] = seg_tab[hi % p_base[i]];
                cap_flag[i] = 1'b1;
            end
            if (clr) begin
                mv[i] = 0;
                ml[i] = 1'b0;
            end else if (pend[i] && en) begin
                if (!dir) begin
                    if (mv[i] == modv - 1) ml[i] = 1'b1;
                    mv[i] = (mv[i] + 1) % modv;
                end else if (mv[i] == 0) begin
                    ml[i] = 1'b1;
                    mv[i] = modv - 1;
                end else begin
                    mv[i] = mv[i] - 1;
                end
            end
            pend[i] = 1'b0;
            if (s2 == mdb[i]) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == p_db[i]) begin
                    mdb[i] = s2;
                    run[i] = 0;
                    if (s2 && armed[i]) pend[i] = 1'b1;
                end
            end
            if (k >= 3 && !s2) armed[i] = 1'b1;
        end
        h2 = h1;
        h1 = btnc;
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst A.value", 32'(value_a), 32'h0);
        chk("rst A.led0",  32'(led_a),   32'h0);
        chk("rst A.an",    32'(an_a),    32'h2);
        chk("rst A.swg",   32'(swg_a),   32'h40);
        chk("rst B.value", 32'(value_b), 32'h0);
        chk("rst B.an",    32'(an_b),    32'h6);
        chk("rst B.swg",   32'(swg_b),   32'h40);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press();
        btnc = 1'b1;
        step();
        btnc = 1'b0;
        steps(3);
    endtask

    typedef struct {
        bit         dir;
        bit         en;
        bit         clr;
        int         presses;
        logic [7:0] exp_val;
        bit         exp_led;
    } vec_t;

    vec_t tab[9];

    initial begin
        p_d    = '{2, 3};
        p_base = '{10, 16};
        p_db   = '{1, 4};
        p_sd   = '{4, 3};
        p_lzb  = '{0, 1};
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        tab[0] = '{0, 1, 0, 64, 8'h64, 0};
        tab[1] = '{0, 1, 1,  0, 8'h00, 0};
        tab[2] = '{0, 1, 0, 99, 8'h99, 0};
        tab[3] = '{0, 1, 0,  1, 8'h00, 1};
        tab[4] = '{0, 1, 1,  0, 8'h00, 0};
        tab[5] = '{1, 1, 0,  1, 8'h99, 1};
        tab[6] = '{1, 1, 0,  1, 8'h98, 1};
        tab[7] = '{0, 0, 0,  3, 8'h98, 1};
        tab[8] = '{1, 0, 0,  2, 8'h98, 1};
        model_reset();

        do_reset();
        steps(6);

        for (int t = 0; t < 9; t++) begin
            dir = tab[t].dir;
            en  = tab[t].en;
            if (tab[t].clr) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
            end else begin
                for (int p = 0; p < tab[t].presses; p++) press();
            end
            steps(2);
            chk($sformatf("tab%0d value", t), 32'(value_a), 32'(tab[t].exp_val));
            chk($sformatf("tab%0d led0", t),  32'(led_a),   32'(tab[t].exp_led));
        end

        // Press latency: VALUE moves on the 4th edge after BTNC is first sampled high.
        dir = 1'b0;
        en  = 1'b1;
        btnc = 1'b1;
        step();
        btnc = 1'b0;
        steps(2);
        chk("latency edge3", 32'(value_a), 32'h98);
        step();
        chk("latency edge4", 32'(value_a), 32'h99);
        steps(4);

        // Two-cycle glitch: one press on A, rejected by the 4-cycle debounce of B.
        btnc = 1'b1;
        steps(2);
        btnc = 1'b0;
        steps(10);
        chk("glitch A.value", 32'(value_a), 32'h00);
        chk("glitch B.value", 32'(value_b), 32'h000);
        btnc = 1'b1;
        steps(6);
        btnc = 1'b0;
        steps(10);
        chk("long A.value", 32'(value_a), 32'h01);
        chk("long B.value", 32'(value_b), 32'h001);

        // Reset during a held press: no count until released and pressed again.
        btnc = 1'b1;
        steps(3);
        do_reset();
        steps(12);
        chk("held A.value", 32'(value_a), 32'h00);
        chk("held B.value", 32'(value_b), 32'h000);
        btnc = 1'b0;
        steps(10);
        btnc = 1'b1;
        steps(6);
        btnc = 1'b0;
        steps(10);
        chk("repress A.value", 32'(value_a), 32'h01);
        chk("repress B.value", 32'(value_b), 32'h001);

        // Random runs of BTNC levels with random direction, enable and rare clears.
        for (int r = 0; r < 600; r++) begin
            btnc = $urandom_range(0, 1);
            dir  = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 40) == 0);
            step();
            clr  = 1'b0;
            steps($urandom_range(0, 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
